hold_register_bank: RTL and testbench
=====================================

// Module: hold_register_bank
//
// PURPOSE
//  Clocked, multi-channel successor to the single-channel level latch.
//  CHANNELS independent WIDTH-bit hold registers, each with its own capture enable.
//  Per-channel mode selects follow (flop-equivalent of a transparent latch) or
//  capture-first (sticky hold until released, with overrun detection).
//  Used as a status/sample capture stage ahead of CSR readout; fully synchronous, no latches.
//
// PARAMETERS
//  WIDTH     8   data bits per channel (>=1)
//  CHANNELS  4   number of channels (>=1)
//  CW        $clog2(CHANNELS+1)  derived, width of held_count; not overridable
//
// PORTS
//  clk         in   1               single clock; all state updates on rising edge
//  rst         in   1               synchronous, active-high reset
//  in          in   WIDTH*CHANNELS  channel c data = in[c*WIDTH +: WIDTH]
//  enable      in   CHANNELS        per-channel capture request
//  mode        in   CHANNELS        0 = FOLLOW, 1 = FIRST (per channel)
//  release_i   in   CHANNELS        per-channel release of held value
//  freeze      in   1               global: blocks all captures while high
//  out         out  WIDTH*CHANNELS  held data, same packing as in
//  valid       out  CHANNELS        channel holds data (state HOLD)
//  overrun     out  CHANNELS        sticky: capture refused in FIRST/HOLD
//  held_count  out  CW              number of channels with valid=1
//
// BEHAVIOUR
//  - Reset (rst=1 at edge): all out=0, valid=0, overrun=0, held_count=0; state EMPTY. Overrides all inputs.
//  - All outputs registered; 1-cycle latency: inputs at edge N visible after edge N.
//  - cap = enable[c] & ~freeze. Per-channel FSM {EMPTY, HOLD}, priority top-down:
//    EMPTY: cap -> load in, HOLD. else stay (release ignored, out retains last value).
//    HOLD, FOLLOW: cap -> reload in. release & ~cap -> EMPTY (out retained, valid=0).
//    HOLD, FIRST: release & cap -> reload in, stay HOLD, clear overrun.
//                 release & ~cap -> EMPTY, clear overrun.
//                 ~release & cap -> data unchanged, set overrun.
//                 ~release & enable & freeze -> no change (freeze is not an overrun).
//  - overrun cleared only by release or reset; in FOLLOW it is never set, but a prior
//    value persists until release.
//  - mode sampled every cycle; switching FIRST->FOLLOW while HOLD allows the next cap to reload.
//  - valid[c] = (state==HOLD). held_count = popcount of next valid, registered alongside valid;
//    range 0..CHANNELS, no wrap.
//  - Channels fully independent; simultaneous events on different channels do not interact.
//
// STRUCTURE
//  - Package hold_register_pkg: typedef enum logic {MODE_FOLLOW, MODE_FIRST} hold_mode_t;
//    typedef enum logic {ST_EMPTY, ST_HOLD} hold_state_t.
//  - Sub-module hold_register_channel (WIDTH): one FSM + data + overrun flop;
//    top generates CHANNELS instances and the held_count popcount register.
//
// TESTING
//  1 rst=1 with all inputs toggling -> out=0, valid=0, overrun=0, held_count=0 after edge.
//  2 ch0 FOLLOW, enable=1, in=0x11,0x22,0x33 on 3 edges -> out[7:0]=0x11,0x22,0x33 one cycle
//    later, valid[0]=1.
//  3 ch1 FIRST, enable pulses with 0xA5 then 0x5A -> out=0xA5 held, overrun[1]=1;
//    release_i[1] -> valid[1]=0, overrun[1]=0.
//  4 ch2 FIRST in HOLD (0x01), release+enable same edge with in=0x02 -> out=0x02, valid=1,
//    overrun=0.
//  5 freeze=1, enable=4'hF -> no state change, no overrun; freeze=0 -> all load,
//    held_count=4.
//  6 rst asserted mid-HOLD on all channels -> everything cleared next edge; capture
//    resumes the cycle after rst drops.

Source files
------------

// File: rtl/hold_register_pkg.sv
// Shared types for the multi-channel hold register bank.
// Channel mode selects follow/capture-first behaviour; state tracks whether a channel holds data.
package hold_register_pkg;

    typedef enum logic {
        MODE_FOLLOW = 1'b0,
        MODE_FIRST  = 1'b1
    } hold_mode_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } hold_state_t;

endpackage

// File: rtl/hold_register_channel.sv
// One hold channel: EMPTY/HOLD FSM, captured data and sticky overrun flag.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_EMPTY | no valid data; out_data keeps last value, next capture loads
//   ST_HOLD  | data valid; FOLLOW reloads on capture, FIRST refuses and flags overrun
module hold_register_channel
    import hold_register_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             enable,
    input  hold_mode_t       mode,
    input  logic             release_i,
    input  logic             freeze,
    output logic [WIDTH-1:0] out_data,
    output logic             valid,
    output logic             overrun,
    output logic             valid_next
);

    hold_state_t      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             overrun_q, overrun_d;
    logic             cap;

    assign cap = enable & ~freeze;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (cap) begin
                    data_d  = in_data;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (mode == MODE_FOLLOW) begin
                    if (cap) begin
                        data_d = in_data;
                    end else if (release_i) begin
                        state_d = ST_EMPTY;
                    end
                    // An overrun left over from FIRST mode persists until released.
                    if (release_i) begin
                        overrun_d = 1'b0;
                    end
                end else begin
                    if (release_i && cap) begin
                        data_d    = in_data;
                        overrun_d = 1'b0;
                    end else if (release_i) begin
                        state_d   = ST_EMPTY;
                        overrun_d = 1'b0;
                    end else if (cap) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_data   = data_q;
    assign valid      = (state_q == ST_HOLD);
    assign overrun    = overrun_q;
    assign valid_next = rst ? 1'b0 : (state_d == ST_HOLD);

endmodule

// File: rtl/hold_register_bank.sv
// CHANNELS independent hold registers plus a registered count of channels holding data.
// The count is built from each channel's next-state valid so it lines up with valid.
module hold_register_bank
    import hold_register_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int CW       = $clog2(CHANNELS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH*CHANNELS-1:0]   in,
    input  logic [CHANNELS-1:0]         enable,
    input  logic [CHANNELS-1:0]         mode,
    input  logic [CHANNELS-1:0]         release_i,
    input  logic                        freeze,
    output logic [WIDTH*CHANNELS-1:0]   out,
    output logic [CHANNELS-1:0]         valid,
    output logic [CHANNELS-1:0]         overrun,
    output logic [CW-1:0]               held_count
);

    logic [CHANNELS-1:0] valid_next;
    logic [CW-1:0]       held_count_q, held_count_d;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        hold_register_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .in_data    (in[c*WIDTH +: WIDTH]),
            .enable     (enable[c]),
            .mode       (hold_mode_t'(mode[c])),
            .release_i  (release_i[c]),
            .freeze     (freeze),
            .out_data   (out[c*WIDTH +: WIDTH]),
            .valid      (valid[c]),
            .overrun    (overrun[c]),
            .valid_next (valid_next[c])
        );
    end

    always_comb begin
        held_count_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            held_count_d = held_count_d + CW'(valid_next[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_count_q <= '0;
        end else begin
            held_count_q <= held_count_d;
        end
    end

    assign held_count = held_count_q;

endmodule

// File: tb/tb_hold_register_bank.sv
// Directed plus random bench for hold_register_bank; expectations come from a
// behavioural model pushed into a scoreboard queue and popped after each edge.
module tb_hold_register_bank;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int CW       = $clog2(CHANNELS + 1);

    logic                      clk;
    logic                      rst;
    logic [WIDTH*CHANNELS-1:0] in;
    logic [CHANNELS-1:0]       enable;
    logic [CHANNELS-1:0]       mode;
    logic [CHANNELS-1:0]       release_i;
    logic                      freeze;
    logic [WIDTH*CHANNELS-1:0] out;
    logic [CHANNELS-1:0]       valid;
    logic [CHANNELS-1:0]       overrun;
    logic [CW-1:0]             held_count;

    hold_register_bank #(
        .WIDTH(WIDTH),
        .CHANNELS(CHANNELS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in),
        .enable     (enable),
        .mode       (mode),
        .release_i  (release_i),
        .freeze     (freeze),
        .out        (out),
        .valid      (valid),
        .overrun    (overrun),
        .held_count (held_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH*CHANNELS-1:0] out;
        logic [CHANNELS-1:0]       valid;
        logic [CHANNELS-1:0]       ovr;
        logic [CW-1:0]             cnt;
    } exp_t;

    exp_t sb[$];

    logic [WIDTH-1:0]    m_out [CHANNELS];
    logic [CHANNELS-1:0] m_valid;
    logic [CHANNELS-1:0] m_ovr;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one rising edge, from the channel rules.
    task automatic model_edge();
        logic cap;
        for (int c = 0; c < CHANNELS; c++) begin
            cap = enable[c] & ~freeze;
            if (rst) begin
                m_out[c]   = '0;
                m_valid[c] = 1'b0;
                m_ovr[c]   = 1'b0;
            end else if (!m_valid[c]) begin
                if (cap) begin
                    m_out[c]   = in[c*WIDTH +: WIDTH];
                    m_valid[c] = 1'b1;
                end
            end else if (!mode[c]) begin
                if (cap) m_out[c] = in[c*WIDTH +: WIDTH];
                else if (release_i[c]) m_valid[c] = 1'b0;
                if (release_i[c]) m_ovr[c] = 1'b0;
            end else begin
                if (release_i[c] && cap) begin
                    m_out[c] = in[c*WIDTH +: WIDTH];
                    m_ovr[c] = 1'b0;
                end else if (release_i[c]) begin
                    m_valid[c] = 1'b0;
                    m_ovr[c]   = 1'b0;
                end else if (cap) begin
                    m_ovr[c] = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [31:0] d,
                        input logic [3:0] en, input logic [3:0] md,
                        input logic [3:0] rel, input logic frz);
        exp_t e;
        exp_t got;
        rst = r; in = d; enable = en; mode = md; release_i = rel; freeze = frz;
        model_edge();
        for (int c = 0; c < CHANNELS; c++) e.out[c*WIDTH +: WIDTH] = m_out[c];
        e.valid = m_valid;
        e.ovr   = m_ovr;
        e.cnt   = CW'($countones(m_valid));
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({tag, ".out"},     out,        got.out);
        chk({tag, ".valid"},   valid,      got.valid);
        chk({tag, ".overrun"}, overrun,    got.ovr);
        chk({tag, ".count"},   held_count, got.cnt);
    endtask

    initial begin
        rst = 1'b1; in = '0; enable = '0; mode = '0; release_i = '0; freeze = 1'b0;
        for (int c = 0; c < CHANNELS; c++) m_out[c] = '0;
        m_valid = '0;
        m_ovr   = '0;

        // 1: reset dominates toggling inputs
        step("rst_a", 1'b1, 32'hDEAD_BEEF, 4'hF, 4'hA, 4'h5, 1'b0);
        step("rst_b", 1'b1, 32'h1234_5678, 4'hF, 4'h5, 4'hA, 1'b1);
        chk("rst_out", out, 32'h0);
        chk("rst_cnt", held_count, 3'd0);

        // 2: ch0 FOLLOW tracks every capture
        step("fol1", 1'b0, 32'h0000_0011, 4'h1, 4'h0, 4'h0, 1'b0);
        chk("fol1_ch0", out[7:0], 8'h11);
        step("fol2", 1'b0, 32'h0000_0022, 4'h1, 4'h0, 4'h0, 1'b0);
        chk("fol2_ch0", out[7:0], 8'h22);
        step("fol3", 1'b0, 32'h0000_0033, 4'h1, 4'h0, 4'h0, 1'b0);
        chk("fol3_ch0", out[7:0], 8'h33);
        chk("fol3_v0", valid[0], 1'b1);

        // 3: ch1 FIRST holds the first value and flags the refused capture
        step("fst1", 1'b0, 32'h0000_A500, 4'h2, 4'h2, 4'h0, 1'b0);
        step("fst_idle", 1'b0, 32'h0000_0000, 4'h0, 4'h2, 4'h0, 1'b0);
        step("fst2", 1'b0, 32'h0000_5A00, 4'h2, 4'h2, 4'h0, 1'b0);
        chk("fst2_ch1", out[15:8], 8'hA5);
        chk("fst2_ovr1", overrun[1], 1'b1);
        step("fst_rel", 1'b0, 32'h0000_0000, 4'h0, 4'h2, 4'h2, 1'b0);
        chk("fst_rel_v1", valid[1], 1'b0);
        chk("fst_rel_ovr1", overrun[1], 1'b0);
        chk("fst_rel_ch1", out[15:8], 8'hA5);

        // 4: ch2 FIRST release+capture reloads and clears overrun
        step("rc_ld", 1'b0, 32'h0001_0000, 4'h4, 4'h4, 4'h0, 1'b0);
        step("rc_ovr", 1'b0, 32'h0007_0000, 4'h4, 4'h4, 4'h0, 1'b0);
        step("rc_both", 1'b0, 32'h0002_0000, 4'h4, 4'h4, 4'h4, 1'b0);
        chk("rc_ch2", out[23:16], 8'h02);
        chk("rc_v2", valid[2], 1'b1);
        chk("rc_ovr2", overrun[2], 1'b0);

        // FIRST -> FOLLOW switch while holding lets the next capture reload
        step("sw_ld", 1'b0, 32'h0000_3C00, 4'h2, 4'h2, 4'h0, 1'b0);
        step("sw_fol", 1'b0, 32'h0000_C300, 4'h2, 4'h0, 4'h0, 1'b0);
        chk("sw_ch1", out[15:8], 8'hC3);

        // 5: freeze blocks captures without overrun
        step("clr", 1'b0, 32'h0, 4'h0, 4'h0, 4'hF, 1'b0);
        chk("clr_cnt", held_count, 3'd0);
        step("frz1", 1'b0, 32'h4433_2211, 4'hF, 4'hF, 4'h0, 1'b1);
        chk("frz1_cnt", held_count, 3'd0);
        step("frz_ld", 1'b0, 32'h4433_2211, 4'hF, 4'hF, 4'h0, 1'b0);
        chk("frz_ld_cnt", held_count, 3'd4);
        chk("frz_ld_out", out, 32'h4433_2211);
        step("frz2", 1'b0, 32'h8877_6655, 4'hF, 4'hF, 4'h0, 1'b1);
        chk("frz2_ovr", overrun, 4'h0);
        chk("frz2_out", out, 32'h4433_2211);

        // 6: reset mid-hold, then capture resumes
        step("ovr_set", 1'b0, 32'h8877_6655, 4'hF, 4'hF, 4'h0, 1'b0);
        step("mid_rst", 1'b1, 32'h8877_6655, 4'hF, 4'hF, 4'h0, 1'b0);
        chk("mid_rst_v", valid, 4'h0);
        step("resume", 1'b0, 32'hCAFE_F00D, 4'hF, 4'h0, 4'h0, 1'b0);
        chk("resume_out", out, 32'hCAFE_F00D);
        chk("resume_cnt", held_count, 3'd4);

        // random traffic against the model
        for (int i = 0; i < 200; i++) begin
            step("rnd", ($urandom_range(0, 31) == 0), $urandom,
                 4'($urandom), 4'($urandom), 4'($urandom & $urandom), ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
